// File: rtl/fpmul_pipe_if.sv
// Handshake bundle for fpmul_pipe: operand pair in, product and flags out.
// A transfer occurs on a rising edge where valid and ready are both high; valid never waits on ready.
interface fpmul_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic [3:0]   flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y, flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y, flags
  );
endinterface

// File: rtl/fpmul_pipe.sv
// Three-stage floating-point multiplier, round-to-nearest-even, denormals flushed to zero.
// Flags are {invalid, overflow, underflow, inexact} and travel with y.
module fpmul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic        clk,
  input logic        reset,
  fpmul_pipe_if.slave io
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int XW   = EXP_W + 2;

  typedef enum logic [1:0] {K_NORM, K_ZERO, K_INF, K_NAN} kind_t;

  // A stage loads when it is empty or its successor is loading this edge.
  logic v1, v2, v3;
  logic en1, en2, en3;
  assign en3         = !v3 || io.out_ready;
  assign en2         = !v2 || en3;
  assign en1         = !v1 || en2;
  assign io.in_ready = en1;

  // Stage 1: unpack, classify, multiply significands, sum exponents.
  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  logic               za, zb, ia, ib, na, nb;
  kind_t              kind_d;
  logic               inv_d;
  logic [PW-1:0]      prod_d;
  logic [XW-1:0]      exp_d;

  assign {sa, ea, fa} = io.a;
  assign {sb, eb, fb} = io.b;

  always_comb begin
    za     = (ea == '0);
    zb     = (eb == '0);
    ia     = (ea == '1) && (fa == '0);
    ib     = (eb == '1) && (fb == '0);
    na     = (ea == '1) && (fa != '0);
    nb     = (eb == '1) && (fb != '0);
    inv_d  = (ia && zb) || (za && ib);
    kind_d = K_NORM;
    if (na || nb || inv_d) kind_d = K_NAN;
    else if (ia || ib)     kind_d = K_INF;
    else if (za || zb)     kind_d = K_ZERO;
    prod_d = PW'({1'b1, fa}) * PW'({1'b1, fb});
    exp_d  = XW'(ea) + XW'(eb) - XW'(BIAS);
  end

  logic          s1_sign;
  kind_t         s1_kind;
  logic          s1_inv;
  logic [PW-1:0] s1_prod;
  logic [XW-1:0] s1_exp;

  // Stage 2: normalise so the leading one sits at the top bit, then round.
  logic [PW-1:0]    norm;
  logic [XW-1:0]    exp_n;
  logic [MAN_W-1:0] frac_t;
  logic             guard, rnd, sticky, inc;
  logic [MAN_W:0]   sum;
  logic [MAN_W-1:0] frac_r;
  logic [XW-1:0]    exp_r;
  logic             inx_r;

  always_comb begin
    norm   = s1_prod[PW-1] ? s1_prod : {s1_prod[PW-2:0], 1'b0};
    exp_n  = s1_exp + XW'(s1_prod[PW-1]);
    frac_t = norm[PW-2 -: MAN_W];
    guard  = norm[MAN_W];
    rnd    = norm[MAN_W-1];
    sticky = |norm[MAN_W-2:0];
    inc    = guard && (rnd || sticky || frac_t[0]);
    // A carry out of the fraction means the significand rolled over to 10.000.
    sum    = {1'b0, frac_t} + (MAN_W + 1)'(inc);
    frac_r = sum[MAN_W-1:0];
    exp_r  = exp_n + XW'(sum[MAN_W]);
    inx_r  = guard || rnd || sticky;
  end

  logic             s2_sign;
  kind_t            s2_kind;
  logic             s2_inv;
  logic [MAN_W-1:0] s2_frac;
  logic [XW-1:0]    s2_exp;
  logic             s2_inx;

  // Stage 3: range check on the rounded exponent, special select, pack.
  logic [W-1:0] y_d;
  logic [3:0]   flags_d;
  logic         ovf, unf;

  always_comb begin
    unf     = s2_exp[XW-1] || (s2_exp == '0);
    ovf     = !s2_exp[XW-1] && (s2_exp >= XW'(EMAX));
    y_d     = {s2_sign, s2_exp[EXP_W-1:0], s2_frac};
    flags_d = {3'b000, s2_inx};
    case (s2_kind)
      K_NAN: begin
        y_d     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        flags_d = {s2_inv, 3'b000};
      end
      K_INF: begin
        y_d     = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        flags_d = 4'b0000;
      end
      K_ZERO: begin
        y_d     = {s2_sign, {(W-1){1'b0}}};
        flags_d = 4'b0000;
      end
      default: begin
        if (ovf) begin
          y_d     = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d = 4'b0101;
        end else if (unf) begin
          y_d     = {s2_sign, {(W-1){1'b0}}};
          flags_d = 4'b0011;
        end
      end
    endcase
  end

  logic [W-1:0] y_q;
  logic [3:0]   flags_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      y_q     <= '0;
      flags_q <= '0;
    end else begin
      if (en1) v1 <= io.in_valid;
      if (en2) v2 <= v1;
      if (en3) v3 <= v2;
      if (en3 && v2) begin
        y_q     <= y_d;
        flags_q <= flags_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en1 && io.in_valid) begin
      s1_sign <= sa ^ sb;
      s1_kind <= kind_d;
      s1_inv  <= inv_d;
      s1_prod <= prod_d;
      s1_exp  <= exp_d;
    end
    if (en2 && v1) begin
      s2_sign <= s1_sign;
      s2_kind <= s1_kind;
      s2_inv  <= s1_inv;
      s2_frac <= frac_r;
      s2_exp  <= exp_r;
      s2_inx  <= inx_r;
    end
  end

  assign io.out_valid = v3;
  assign io.y         = y_q;
  assign io.flags     = flags_q;
endmodule

// File: tb/tb_fpmul_pipe.sv
// Bench for fpmul_pipe: float32 and half instances, directed vectors plus
// randomized streams scored against an exact-integer rounding model.
module tb_fpmul_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpmul_pipe_if #(.EXP_W(8), .MAN_W(23)) fi ();
  fpmul_pipe_if #(.EXP_W(5), .MAN_W(10)) hi ();

  fpmul_pipe #(.EXP_W(8), .MAN_W(23)) dut_f (.clk(clk), .reset(rst), .io(fi.slave));
  fpmul_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (.clk(clk), .reset(rst), .io(hi.slave));

  int n_tests = 0;
  int n_fail  = 0;
  logic [35:0] exp_q[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Exact product as an integer, rounded by remainder comparison against half an ulp.
  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input int ew, input int mw);
    int          emax, bias, ea, eb, msb, s, e;
    longint      fmask, fa, fb, p, q, rem, half;
    logic        sg, za, zb, ia, ib, na, nb, inv, inx;
    logic [31:0] sbit, einf;
    emax  = (1 << ew) - 1;
    bias  = (1 << (ew - 1)) - 1;
    fmask = (longint'(1) << mw) - 1;
    ea    = int'((a >> mw) & 32'(emax));
    eb    = int'((b >> mw) & 32'(emax));
    fa    = longint'(a) & fmask;
    fb    = longint'(b) & fmask;
    sg    = a[ew+mw] ^ b[ew+mw];
    sbit  = 32'(sg) << (ew + mw);
    einf  = 32'(emax) << mw;
    za = (ea == 0);  zb = (eb == 0);
    ia = (ea == emax) && (fa == 0);  ib = (eb == emax) && (fb == 0);
    na = (ea == emax) && (fa != 0);  nb = (eb == emax) && (fb != 0);
    inv = (ia && zb) || (za && ib);
    if (na || nb || inv) return {inv, 3'b000, einf | (32'd1 << (mw - 1))};
    if (ia || ib) return {4'b0000, sbit | einf};
    if (za || zb) return {4'b0000, sbit};
    p = (fa | (longint'(1) << mw)) * (fb | (longint'(1) << mw));
    msb = 0;
    for (int i = 0; i < 62; i++) if (p[i]) msb = i;
    s    = msb - mw;
    q    = p >> s;
    rem  = p - (q << s);
    half = longint'(1) << (s - 1);
    e    = ea + eb - bias + msb - 2 * mw;
    inx  = (rem != 0);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (longint'(1) << (mw + 1))) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= emax) return {4'b0101, sbit | einf};
    if (e <= 0) return {4'b0011, sbit};
    return {3'b000, inx, sbit | (32'(e) << mw) | 32'(q & fmask)};
  endfunction

  function automatic logic [31:0] rand_op(input int ew, input int mw);
    int          emax, bias;
    logic [31:0] s, e, f;
    emax = (1 << ew) - 1;
    bias = (1 << (ew - 1)) - 1;
    s = 32'($urandom_range(0, 1));
    f = $urandom & 32'((1 << mw) - 1);
    e = 32'($urandom_range(1, emax - 1));
    case ($urandom_range(0, 11))
      0: e = 0;
      1: begin e = 32'(emax); f = 0; end
      2: begin e = 32'(emax); if (f == 0) f = 1; end
      3, 4: e = 32'($urandom_range(bias + bias / 2, emax - 1));
      5, 6: e = 32'($urandom_range(1, bias / 2 + 1));
      7: f = 32'((1 << mw) - 1) - 32'($urandom_range(0, 3));
      default: ;
    endcase
    return (s << (ew + mw)) | (e << mw) | f;
  endfunction

  // Called at a falling edge: drive, sample after settling, step one clock.
  task automatic cycle(input bit half, input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                       input logic ordy, output logic ir, output logic ov,
                       output logic [31:0] yo, output logic [3:0] fo);
    if (half) begin
      hi.in_valid = iv; hi.a = ia[15:0]; hi.b = ib[15:0]; hi.out_ready = ordy;
      fi.in_valid = 1'b0; fi.out_ready = 1'b1;
    end else begin
      fi.in_valid = iv; fi.a = ia; fi.b = ib; fi.out_ready = ordy;
      hi.in_valid = 1'b0; hi.out_ready = 1'b1;
    end
    #1;
    if (half) begin
      ir = hi.in_ready; ov = hi.out_valid; yo = {16'h0, hi.y}; fo = hi.flags;
    end else begin
      ir = fi.in_ready; ov = fi.out_valid; yo = fi.y; fo = fi.flags;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_single(input bit half, input logic [31:0] ia, input logic [31:0] ib,
                            output logic acc, output logic got, output int lat,
                            output logic [31:0] yv, output logic [3:0] fv);
    logic ir, ov;
    logic [31:0] yo;
    logic [3:0] fo;
    cycle(half, 1'b1, ia, ib, 1'b1, ir, ov, yo, fo);
    acc = ir; got = 1'b0; lat = 0; yv = '0; fv = '0;
    while (!got && lat < 10) begin
      cycle(half, 1'b0, 32'h0, 32'h0, 1'b1, ir, ov, yo, fo);
      lat++;
      if (ov) begin got = 1'b1; yv = yo; fv = fo; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fi.in_valid = 1'b0; fi.out_ready = 1'b1; fi.a = '0; fi.b = '0;
    hi.in_valid = 1'b0; hi.out_ready = 1'b1; hi.a = '0; hi.b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({fi.out_valid, fi.flags, fi.y} !== 37'h0) begin
      n_fail++; $display("FAIL reset_state_f32: got v=%b f=%h y=%h, expected all 0", fi.out_valid, fi.flags, fi.y);
    end
    n_tests++;
    if ({hi.out_valid, hi.flags, hi.y} !== 21'h0) begin
      n_fail++; $display("FAIL reset_state_half: got v=%b f=%h y=%h, expected all 0", hi.out_valid, hi.flags, hi.y);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (fi.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", fi.in_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] va[10], vb[10], vy[10];
    logic [3:0]  vf[10];
    logic        acc, got;
    int          lat;
    logic [31:0] yv;
    logic [3:0]  fv;
    va = '{32'h3FC00000, 32'hC0400000, 32'h3F800001, 32'h3FFFFFFF, 32'h7F800000,
           32'hFF800000, 32'h7FC00001, 32'h80000000, 32'h7F000000, 32'h00800000};
    vb = '{32'h40000000, 32'h3F000000, 32'h3F800001, 32'h3FFFFFFF, 32'h00000000,
           32'h40000000, 32'h3F800000, 32'h3F800000, 32'h7F000000, 32'h00800000};
    vy = '{32'h40400000, 32'hBFC00000, 32'h3F800002, 32'h407FFFFE, 32'h7FC00000,
           32'hFF800000, 32'h7FC00000, 32'h80000000, 32'h7F800000, 32'h00000000};
    vf = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h8, 4'h0, 4'h0, 4'h0, 4'h5, 4'h3};
    for (int i = 0; i < 10; i++) begin
      run_single(1'b0, va[i], vb[i], acc, got, lat, yv, fv);
      n_tests++;
      if (!(acc && got && lat == 3)) begin
        n_fail++; $display("FAIL basic_latency[%0d]: got acc=%b seen=%b cycles=%0d, expected accepted and 3 cycles", i, acc, got, lat);
      end
      n_tests++;
      if (yv !== vy[i]) begin
        n_fail++; $display("FAIL basic_y[%0d]: got %h expected %h", i, yv, vy[i]);
      end
      n_tests++;
      if (fv !== vf[i]) begin
        n_fail++; $display("FAIL basic_flags[%0d]: got %h expected %h", i, fv, vf[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] pa[6], pb[6];
    logic        ir, ov;
    logic [31:0] yo;
    logic [3:0]  fo;
    logic [35:0] held, e;
    logic        held_set;
    int          k, got;
    for (int i = 0; i < 6; i++) begin
      pa[i] = 32'h3F800000 | (32'(i + 1) << 12);
      pb[i] = 32'hC0000000 | (32'(i * 7 + 3) << 5);
    end
    k = 0; held = '0; held_set = 1'b0; ir = 1'b1; ov = 1'b0; yo = '0; fo = '0;
    for (int c = 0; c < 8; c++) begin
      cycle(1'b0, k < 5, pa[k], pb[k], 1'b0, ir, ov, yo, fo);
      if (k < 5 && ir) begin
        exp_q.push_back(ref_mul(pa[k], pb[k], 8, 23));
        k++;
      end
      if (ov && !held_set) begin held = {fo, yo}; held_set = 1'b1; end
    end
    n_tests++;
    if (k !== 3) begin
      n_fail++; $display("FAIL bp_accepted: got %0d expected 3", k);
    end
    n_tests++;
    if (ir !== 1'b0) begin
      n_fail++; $display("FAIL bp_in_ready: got %b expected 0", ir);
    end
    n_tests++;
    if (!(ov === 1'b1 && held_set && {fo, yo} === held)) begin
      n_fail++; $display("FAIL bp_hold: got v=%b %h expected v=1 %h", ov, {fo, yo}, held);
    end
    n_tests++;
    if (held !== exp_q[0]) begin
      n_fail++; $display("FAIL bp_head_value: got %h expected %h", held, exp_q[0]);
    end
    got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      cycle(1'b0, k < 5, pa[k], pb[k], 1'b1, ir, ov, yo, fo);
      if (ov) begin
        got++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL bp_extra_output: got %h expected none", {fo, yo});
        end else begin
          e = exp_q.pop_front();
          if ({fo, yo} !== e) begin
            n_fail++; $display("FAIL bp_order[%0d]: got %h expected %h", got, {fo, yo}, e);
          end
        end
      end
      if (k < 5 && ir) begin
        exp_q.push_back(ref_mul(pa[k], pb[k], 8, 23));
        k++;
      end
    end
    n_tests++;
    if (got !== 5 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL bp_drain: got %0d outputs, %0d left, expected 5 and 0", got, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midflight();
    logic        ir, ov, acc, got;
    logic [31:0] yo;
    logic [3:0]  fo;
    int          stale, lat;
    for (int c = 0; c < 3; c++) cycle(1'b0, 1'b1, 32'h7F000000, 32'h7F000000, 1'b0, ir, ov, yo, fo);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, ir, ov, yo, fo);
    n_tests++;
    if (!(ov === 1'b1 && fo === 4'h5 && ir === 1'b0)) begin
      n_fail++; $display("FAIL midrst_full: got v=%b f=%h rdy=%b expected v=1 f=5 rdy=0", ov, fo, ir);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if ({fi.out_valid, fi.flags, fi.y} !== 37'h0) begin
      n_fail++; $display("FAIL midrst_clear: got v=%b f=%h y=%h expected all 0", fi.out_valid, fi.flags, fi.y);
    end
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int c = 0; c < 12; c++) begin
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, ir, ov, yo, fo);
      if (ov) stale++;
    end
    n_tests++;
    if (stale !== 0) begin
      n_fail++; $display("FAIL midrst_stale: got %0d outputs expected 0", stale);
    end
    run_single(1'b0, 32'hC0400000, 32'h3F000000, acc, got, lat, yo, fo);
    n_tests++;
    if (!(acc && got && lat == 3 && yo === 32'hBFC00000 && fo === 4'h0)) begin
      n_fail++; $display("FAIL midrst_recover: got y=%h f=%h cycles=%0d expected BFC00000 0 3", yo, fo, lat);
    end
  endtask

  task automatic test_random(input bit half, input int n);
    int          ew, mw, drain;
    logic        iv, ordy, ir, ov, hold_prev;
    logic [31:0] ra, rb, yo;
    logic [3:0]  fo;
    logic [35:0] prev, e;
    ew = half ? 5 : 8;
    mw = half ? 10 : 23;
    hold_prev = 1'b0; prev = '0;
    for (int c = 0; c < n; c++) begin
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 7);
      ra   = rand_op(ew, mw);
      rb   = rand_op(ew, mw);
      cycle(half, iv, ra, rb, ordy, ir, ov, yo, fo);
      if (hold_prev) begin
        n_tests++;
        if (!(ov === 1'b1 && {fo, yo} === prev)) begin
          n_fail++; $display("FAIL rand_stable h=%0d: got v=%b %h expected v=1 %h", half, ov, {fo, yo}, prev);
        end
      end
      if (ov && ordy) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_extra h=%0d: got %h expected none", half, {fo, yo});
        end else begin
          e = exp_q.pop_front();
          if ({fo, yo} !== e) begin
            n_fail++; $display("FAIL rand_result h=%0d: got %h expected %h", half, {fo, yo}, e);
          end
        end
      end
      if (iv && ir) exp_q.push_back(ref_mul(ra, rb, ew, mw));
      hold_prev = ov && !ordy;
      prev = {fo, yo};
    end
    drain = 0;
    while (exp_q.size() != 0 && drain < 20) begin
      cycle(half, 1'b0, 32'h0, 32'h0, 1'b1, ir, ov, yo, fo);
      drain++;
      if (ov) begin
        e = exp_q.pop_front();
        n_tests++;
        if ({fo, yo} !== e) begin
          n_fail++; $display("FAIL rand_drain h=%0d: got %h expected %h", half, {fo, yo}, e);
        end
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rand_lost h=%0d: got %0d pending expected 0", half, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_half();
    logic        acc, got;
    int          lat;
    logic [31:0] yv;
    logic [3:0]  fv;
    run_single(1'b1, 32'h3E00, 32'h4000, acc, got, lat, yv, fv);
    n_tests++;
    if (!(acc && got && lat == 3)) begin
      n_fail++; $display("FAIL half_latency: got acc=%b seen=%b cycles=%0d expected 3", acc, got, lat);
    end
    n_tests++;
    if ({fv, yv} !== {4'h0, 32'h4200}) begin
      n_fail++; $display("FAIL half_basic: got %h %h expected 0 00004200", fv, yv);
    end
    run_single(1'b1, 32'h7800, 32'h7800, acc, got, lat, yv, fv);
    n_tests++;
    if ({fv, yv} !== {4'h5, 32'h7C00}) begin
      n_fail++; $display("FAIL half_overflow: got %h %h expected 5 00007C00", fv, yv);
    end
    test_random(1'b1, 300);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_midflight();
    test_random(1'b0, 600);
    test_half();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
